// File: rtl/mac_pkg.sv
// ============================================================================
// Package     : mac_pkg
// Description : Shared types and constants for the multi-lane MAC array:
//               the per-beat mode encoding, default parameter values and
//               the saturation bound helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

   typedef enum logic [1:0] {
      MAC_EXT = 2'd0,   // r = a*b + c, acc unchanged
      ACC     = 2'd1,   // r = acc + a*b, acc <= r
      LOAD    = 2'd2,   // r = c, acc <= c
      START   = 2'd3    // r = a*b, acc <= r
   } mac_mode_e;

   localparam int DEF_BW     = 8;
   localparam int DEF_LANES  = 4;
   localparam int DEF_ACC_W  = 2*DEF_BW + 4;
   localparam int DEF_SIGNED = 0;
   localparam int DEF_SAT    = 1;

   // Bounds are returned in 64 bits; callers keep the low acc_w bits.
   // The signed minimum is sign-extended, so its low acc_w bits are 100..0.
   function automatic logic [63:0] sat_max(input int acc_w, input bit is_signed);
      if (is_signed) return (64'd1 << (acc_w-1)) - 64'd1;
      else           return (64'd1 << acc_w) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int acc_w, input bit is_signed);
      if (is_signed) return ~64'd0 << (acc_w-1);
      else           return 64'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_lane.sv
// ============================================================================
// Module      : mac_lane
// Description : One lane of the MAC array. S1 registers the product and c;
//               S2 adds, saturates, updates the lane accumulator and
//               registers the result.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_s1_en         - capture a, b, c into S1 (beat accepted)
//               i_s2_en         - S1 holds a valid beat and the pipe advances
//               i_s2_mode       - mode of the beat currently held in S1
//               i_a, i_b        - operands
//               i_c             - addend / load value
//               o_c, o_sat      - registered result and overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_lane
   import mac_pkg::*;
#(
   parameter int BW     = DEF_BW,
   parameter int ACC_W  = 2*BW + 4,
   parameter int SIGNED = DEF_SIGNED,
   parameter int SAT    = DEF_SAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_s1_en,
   input  logic             i_s2_en,
   input  mac_mode_e        i_s2_mode,
   input  logic [BW-1:0]    i_a,
   input  logic [BW-1:0]    i_b,
   input  logic [ACC_W-1:0] i_c,
   output logic [ACC_W-1:0] o_c,
   output logic             o_sat
);

   localparam logic [63:0]      c_MAX64   = sat_max(ACC_W, SIGNED != 0);
   localparam logic [63:0]      c_MIN64   = sat_min(ACC_W, SIGNED != 0);
   localparam logic [ACC_W-1:0] c_SAT_MAX = c_MAX64[ACC_W-1:0];
   localparam logic [ACC_W-1:0] c_SAT_MIN = c_MIN64[ACC_W-1:0];

   logic [2*BW-1:0]  w_prod;
   logic [2*BW-1:0]  r_prod;
   logic [ACC_W-1:0] r_c;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_c;
   logic             r_out_sat;
   logic [ACC_W-1:0] w_prod_ext;
   logic [ACC_W-1:0] w_x;
   logic [ACC_W:0]   w_sum;
   logic             w_ovf_u;
   logic             w_ovf_s;
   logic             w_ovf;
   logic [ACC_W-1:0] w_r;

   generate
      if (SIGNED != 0) begin : g_signed
         assign w_prod     = $signed(i_a) * $signed(i_b);
         assign w_prod_ext = {{(ACC_W-2*BW){r_prod[2*BW-1]}}, r_prod};
      end else begin : g_unsigned
         assign w_prod     = i_a * i_b;
         assign w_prod_ext = {{(ACC_W-2*BW){1'b0}}, r_prod};
      end
   endgenerate

   // S1: operands only move when a beat is actually accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         r_c    <= '0;
      end else if (i_s1_en) begin
         r_prod <= w_prod;
         r_c    <= i_c;
      end
   end

   // S2 add: one extra bit so the unsigned carry-out is visible directly.
   assign w_x     = (i_s2_mode == MAC_EXT) ? r_c : r_acc;
   assign w_sum   = {1'b0, w_x} + {1'b0, w_prod_ext};
   assign w_ovf_u = w_sum[ACC_W];
   assign w_ovf_s = (w_x[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                    (w_sum[ACC_W-1] != w_x[ACC_W-1]);

   always_comb begin
      w_ovf = 1'b0;
      w_r   = w_sum[ACC_W-1:0];
      case (i_s2_mode)
         LOAD:    w_r = r_c;
         START:   w_r = w_prod_ext;
         default: begin
            w_ovf = (SIGNED != 0) ? w_ovf_s : w_ovf_u;
            // Unsigned adds can only overflow upward; signed overflow
            // direction follows the (shared) sign of the operands.
            if (w_ovf && (SAT != 0))
               w_r = ((SIGNED != 0) && w_x[ACC_W-1]) ? c_SAT_MIN : c_SAT_MAX;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_out_c   <= '0;
         r_out_sat <= 1'b0;
      end else if (i_s2_en) begin
         r_out_c   <= w_r;
         r_out_sat <= w_ovf;
         if (i_s2_mode != MAC_EXT)
            r_acc <= w_r;
      end
   end

   assign o_c   = r_out_c;
   assign o_sat = r_out_sat;

endmodule

`default_nettype wire

// File: rtl/mac_lane_array.sv
// ============================================================================
// Module      : mac_lane_array
// Description : LANES-wide pipelined multiply-accumulate with valid/ready
//               handshakes on both sides. Two stages; the whole pipe
//               freezes while a result is held by downstream.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid/in_ready   - input beat handshake
//               in_mode             - mac_mode_e for every lane of the beat
//               in_a, in_b          - LANES x BW packed operands
//               in_c                - LANES x ACC_W packed addends
//               out_valid/out_ready - result beat handshake
//               out_c               - LANES x ACC_W packed results
//               out_sat             - per-lane overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_lane_array
   import mac_pkg::*;
#(
   parameter int BW     = DEF_BW,
   parameter int LANES  = DEF_LANES,
   parameter int ACC_W  = 2*BW + 4,
   parameter int SIGNED = DEF_SIGNED,
   parameter int SAT    = DEF_SAT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_mode,
   input  logic [LANES*BW-1:0]    in_a,
   input  logic [LANES*BW-1:0]    in_b,
   input  logic [LANES*ACC_W-1:0] in_c,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*ACC_W-1:0] out_c,
   output logic [LANES-1:0]       out_sat
);

   logic      r_s1_vld;
   logic      r_s2_vld;
   mac_mode_e r_s1_mode;
   logic      w_stall;
   logic      w_adv;
   logic      w_accept;
   logic      w_s2_en;

   // Bubbles are not collapsed: only a valid, unconsumed result stalls.
   assign w_stall  = r_s2_vld & ~out_ready;
   assign w_adv    = ~w_stall;
   assign in_ready = w_adv;
   assign w_accept = in_valid & w_adv;
   assign w_s2_en  = r_s1_vld & w_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s2_vld  <= 1'b0;
         r_s1_mode <= MAC_EXT;
      end else if (w_adv) begin
         r_s1_vld <= in_valid;
         r_s2_vld <= r_s1_vld;
         if (in_valid)
            r_s1_mode <= mac_mode_e'(in_mode);
      end
   end

   assign out_valid = r_s2_vld;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         mac_lane #(
            .BW     (BW),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED),
            .SAT    (SAT)
         ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_s1_en   (w_accept),
            .i_s2_en   (w_s2_en),
            .i_s2_mode (r_s1_mode),
            .i_a       (in_a[i*BW +: BW]),
            .i_b       (in_b[i*BW +: BW]),
            .i_c       (in_c[i*ACC_W +: ACC_W]),
            .o_c       (out_c[i*ACC_W +: ACC_W]),
            .o_sat     (out_sat[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mac_lane_array.sv
// ============================================================================
// Module      : tb_mac_lane_array
// Description : Bench for mac_lane_array. Four instances share stimulus and
//               cover every SIGNED/SAT combination; instance k has
//               SIGNED = k/2 and SAT = 1 - k%2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_lane_array;
   import mac_pkg::*;

   localparam int BW    = 8;
   localparam int LANES = 4;
   localparam int ACC_W = 2*BW + 4;
   localparam int NI    = 4;

   typedef struct packed {
      logic [NI-1:0][LANES*ACC_W-1:0] c;
      logic [NI-1:0][LANES-1:0]       s;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic [1:0]             in_mode;
   logic [LANES*BW-1:0]    in_a;
   logic [LANES*BW-1:0]    in_b;
   logic [LANES*ACC_W-1:0] in_c;
   logic                   out_ready;
   logic [NI-1:0]          ir;
   logic [NI-1:0]          ov;
   logic [LANES*ACC_W-1:0] oc [NI];
   logic [LANES-1:0]       os [NI];

   int n_checks = 0;
   int n_fail   = 0;
   int n_recv   = 0;
   exp_t q[$];
   logic [ACC_W-1:0]       macc [NI][LANES];
   logic [LANES*ACC_W-1:0] last_oc [NI];
   logic [LANES-1:0]       last_os [NI];

   always #5 clk = ~clk;

   generate
      for (genvar k = 0; k < NI; k++) begin : g_dut
         mac_lane_array #(
            .BW(BW), .LANES(LANES), .ACC_W(ACC_W),
            .SIGNED(k/2), .SAT(1 - (k%2))
         ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(ir[k]), .in_mode(in_mode),
            .in_a(in_a), .in_b(in_b), .in_c(in_c),
            .out_valid(ov[k]), .out_ready(out_ready),
            .out_c(oc[k]), .out_sat(os[k])
         );
      end
   endgenerate

   // Reference model: exact integer arithmetic, overflow = out of range.
   task automatic model_step(input logic [1:0] m, input logic [LANES*BW-1:0] a,
                             input logic [LANES*BW-1:0] b, input logic [LANES*ACC_W-1:0] c);
      exp_t e;
      e = '0;
      for (int k = 0; k < NI; k++) begin
         bit sgn = (k/2) != 0;
         bit sat = (k%2) == 0;
         longint maxv = sgn ? (64'sd1 <<< (ACC_W-1)) - 1 : (64'sd1 <<< ACC_W) - 1;
         longint minv = sgn ? -(64'sd1 <<< (ACC_W-1)) : 64'sd0;
         for (int l = 0; l < LANES; l++) begin
            logic [BW-1:0]    la, lb;
            logic [ACC_W-1:0] lc, lacc, rb;
            longint av, bv, cv, accv, sum, r;
            bit ovf;
            la = a[l*BW +: BW];
            lb = b[l*BW +: BW];
            lc = c[l*ACC_W +: ACC_W];
            lacc = macc[k][l];
            av   = sgn ? longint'($signed(la))   : longint'(la);
            bv   = sgn ? longint'($signed(lb))   : longint'(lb);
            cv   = sgn ? longint'($signed(lc))   : longint'(lc);
            accv = sgn ? longint'($signed(lacc)) : longint'(lacc);
            case (m)
               2'd0:    sum = av*bv + cv;
               2'd1:    sum = accv + av*bv;
               2'd2:    sum = cv;
               default: sum = av*bv;
            endcase
            ovf = (sum > maxv) || (sum < minv);
            r = (ovf && sat) ? ((sum > maxv) ? maxv : minv) : sum;
            rb = r[ACC_W-1:0];
            e.c[k][l*ACC_W +: ACC_W] = rb;
            e.s[k][l] = ovf;
            if (m != 2'd0) macc[k][l] = rb;
         end
      end
      q.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++)
         for (int l = 0; l < LANES; l++)
            macc[k][l] = '0;
   endtask

   // Monitor: pops one expectation per result handed downstream.
   always begin
      exp_t e;
      @(negedge clk); #2;
      if (rst_n && ov[0] && out_ready) begin
         if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output out_c=%h", oc[0]);
         end else begin
            e = q.pop_front();
            n_recv++;
            for (int k = 0; k < NI; k++) begin
               n_checks++;
               if (oc[k] !== e.c[k] || os[k] !== e.s[k] || ov[k] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL scoreboard inst=%0d got c=%h sat=%b valid=%b exp c=%h sat=%b",
                           k, oc[k], os[k], ov[k], e.c[k], e.s[k]);
               end
               last_oc[k] = oc[k];
               last_os[k] = os[k];
            end
         end
      end
   end

   task automatic send(input logic [1:0] m, input logic [LANES*BW-1:0] a,
                       input logic [LANES*BW-1:0] b, input logic [LANES*ACC_W-1:0] c);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_c = c;
      #2;
      while (!ir[0] && t < 50) begin
         @(negedge clk); #2; t++;
      end
      if (t >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout in_ready=%b required 1", ir[0]);
      end
      @(posedge clk);
      model_step(m, a, b, c);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 100) begin
         @(negedge clk); t++;
      end
      @(negedge clk); #3;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout pending=%0d required 0", q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'd0; in_a = '0; in_b = '0; in_c = '0;
      out_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #2;
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (ov[k] !== 1'b0 || oc[k] !== '0 || os[k] !== '0 || ir[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state inst=%0d valid=%b c=%h sat=%b ready=%b required 0/0/0/1",
                     k, ov[k], oc[k], os[k], ir[k]);
         end
      end
   endtask

   task automatic test_basic();
      send(2'd0, {LANES{8'd3}}, {LANES{8'd5}}, {LANES{20'd7}});
      // Acceptance edge has passed; result must appear on the next edge.
      n_checks++;
      if (ov[0] !== 1'b0) begin
         n_fail++; $display("FAIL latency_early out_valid=%b required 0", ov[0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ov[0] !== 1'b1 || oc[0] !== {LANES{20'd22}} || os[0] !== '0) begin
         n_fail++;
         $display("FAIL latency_result valid=%b c=%h sat=%b required 1/%h/0",
                  ov[0], oc[0], os[0], {LANES{20'd22}});
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int r0 = n_recv;
      send(2'd3, {LANES{8'd2}}, {LANES{8'd3}}, '0);
      send(2'd1, {LANES{8'd4}}, {LANES{8'd5}}, '0);
      send(2'd1, {LANES{8'd1}}, {LANES{8'd1}}, '0);
      drain();
      n_checks++;
      if (last_oc[0] !== {LANES{20'd27}} || n_recv - r0 != 3) begin
         n_fail++;
         $display("FAIL acc_chain c=%h beats=%0d required %h/3", last_oc[0], n_recv - r0, {LANES{20'd27}});
      end
      // A zero-product ACC exposes the stored accumulator.
      send(2'd1, '0, '0, '0);
      drain();
      n_checks++;
      if (last_oc[0] !== {LANES{20'd27}}) begin
         n_fail++; $display("FAIL acc_value c=%h required %h", last_oc[0], {LANES{20'd27}});
      end
   endtask

   task automatic test_saturate();
      send(2'd2, '0, '0, {LANES{20'h7FFF6}});
      send(2'd1, {LANES{8'd4}}, {LANES{8'd4}}, '0);
      drain();
      n_checks++;
      if (last_oc[2] !== {LANES{20'h7FFFF}} || last_os[2] !== 4'hF) begin
         n_fail++; $display("FAIL signed_sat c=%h sat=%b required %h/1111", last_oc[2], last_os[2], {LANES{20'h7FFFF}});
      end
      n_checks++;
      if (last_oc[3] !== {LANES{20'h80006}} || last_os[3] !== 4'hF) begin
         n_fail++; $display("FAIL signed_wrap c=%h sat=%b required %h/1111", last_oc[3], last_os[3], {LANES{20'h80006}});
      end
      n_checks++;
      if (last_oc[0] !== {LANES{20'h80006}} || last_os[0] !== 4'h0) begin
         n_fail++; $display("FAIL unsigned_nosat c=%h sat=%b required %h/0000", last_oc[0], last_os[0], {LANES{20'h80006}});
      end
   endtask

   task automatic test_stall();
      int r0 = n_recv;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic [LANES*ACC_W-1:0] c;
               c = {LANES{20'(i*1000 + 17)}};
               send(2'd0, {LANES{8'(i+1)}}, {LANES{8'd9}}, c);
            end
         end
         begin
            int t = 0;
            logic [LANES*ACC_W-1:0] snap;
            while (!ov[0] && t < 20) begin @(negedge clk); t++; end
            @(negedge clk); @(negedge clk);
            out_ready = 1'b0;
            #2 snap = oc[0];
            for (int j = 0; j < 3; j++) begin
               n_checks++;
               if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || oc[0] !== snap) begin
                  n_fail++;
                  $display("FAIL stall_hold cyc=%0d ready=%b valid=%b c=%h required 0/1/%h",
                           j, ir[0], ov[0], oc[0], snap);
               end
               if (j < 2) begin @(negedge clk); #2; end
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      n_checks++;
      if (n_recv - r0 != 6) begin
         n_fail++; $display("FAIL stall_count beats=%0d required 6", n_recv - r0);
      end
   endtask

   task automatic test_reset_inflight();
      send(2'd2, '0, '0, {LANES{20'd100}});
      drain();
      send(2'd1, {LANES{8'd1}}, {LANES{8'd1}}, '0);
      send(2'd1, {LANES{8'd1}}, {LANES{8'd1}}, '0);
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (ov[k] !== 1'b0 || oc[k] !== '0 || os[k] !== '0) begin
            n_fail++;
            $display("FAIL reset_flush inst=%0d valid=%b c=%h sat=%b required 0/0/0", k, ov[k], oc[k], os[k]);
         end
      end
      q.delete();
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      send(2'd1, {LANES{8'd1}}, {LANES{8'd1}}, '0);
      drain();
      n_checks++;
      if (last_oc[0] !== {LANES{20'd1}}) begin
         n_fail++; $display("FAIL post_reset_acc c=%h required %h", last_oc[0], {LANES{20'd1}});
      end
   endtask

   task automatic test_random();
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               logic [LANES*BW-1:0]    a, b;
               logic [LANES*ACC_W-1:0] c;
               a = $urandom; b = $urandom;
               c = {$urandom, $urandom, $urandom};
               send(2'($urandom_range(0, 3)), a, b, c);
            end
         end
         begin
            for (int i = 0; i < 80; i++) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_saturate();
      test_stall();
      test_reset_inflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
